// File: rtl/frame_fifo_pkg.sv
// frame_fifo_pkg: shared types and helpers for sync_frame_fifo.
//   marker_t   : SOP/EOP sideband stored with every data word.
//                Each entry is {sop, eop, data}.
//   err_idx_e  : bit positions of the sticky error flags.
//   lvl_width  : width of pointers, levels and thresholds for a given depth.
//                The extra MSB distinguishes a full FIFO from an empty one.
package frame_fifo_pkg;

    typedef struct packed {
        logic sop;
        logic eop;
    } marker_t;

    typedef enum logic [1:0] {
        ERR_OVERFLOW  = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_FRAME     = 2'd2
    } err_idx_e;

    localparam int ERR_N = 3;

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/frame_fifo_mem.sv
// frame_fifo_mem: simple dual-port RAM with a synchronous write port and a
// registered read port.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read port; rdata updates on the edge after re and holds
//                  its value otherwise
//   rdata        : registered read data
module frame_fifo_mem
    import frame_fifo_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // No reset on the array or the read register so the RAM maps onto
    // block memory; the top masks rdata until the first real read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_frame_fifo.sv
// sync_frame_fifo: single-clock frame FIFO with SOP/EOP sideband.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   wr_en/wr_sop/wr_eop/wr_data  : write side
//   rd_en                        : read strobe; rd_data/rd_sop/rd_eop/rd_valid
//                                  follow one cycle later
//   af_thresh/ae_thresh          : almost-full / almost-empty thresholds
//   full/empty/almost_full/almost_empty, wr_lvl, rd_lvl, frame_cnt : status
//   overflow/underflow/frame_err : sticky errors, cleared by clr_err
//   frame_drop                   : one-cycle pulse when a partial frame is rewound
// STORE_FWD=1 exposes only committed (EOP-terminated) frames to the reader.
// STORE_FWD=0 exposes every written word.
module sync_frame_fifo
    import frame_fifo_pkg::*;
#(
    parameter int  DATA_W    = 32,
    parameter int  DEPTH     = 32,
    parameter bit  STORE_FWD = 1'b1,
    localparam int LVL_W     = lvl_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sop,
    input  logic              wr_eop,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_sop,
    output logic              rd_eop,
    output logic              rd_valid,
    input  logic [LVL_W-1:0]  af_thresh,
    input  logic [LVL_W-1:0]  ae_thresh,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [LVL_W-1:0]  wr_lvl,
    output logic [LVL_W-1:0]  rd_lvl,
    output logic [LVL_W-1:0]  frame_cnt,
    output logic              overflow,
    output logic              underflow,
    output logic              frame_err,
    output logic              frame_drop,
    input  logic              clr_err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + 2;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

    logic [LVL_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [LVL_W-1:0] commit_ptr_reg, commit_ptr_next;
    logic [LVL_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [LVL_W-1:0] wr_lvl_reg, wr_lvl_next;
    logic [LVL_W-1:0] rd_lvl_reg, rd_lvl_next;
    logic [LVL_W-1:0] wr_addr_ptr;
    logic             in_frame_reg, in_frame_next;
    logic             drop_reg, drop_next;
    logic             full_reg, empty_reg, almost_full_reg, almost_empty_reg;
    logic             rd_valid_reg, data_seen_reg, frame_drop_reg;
    logic             mem_we, commit, drop_pulse, rd_acc, rd_eop_dec;
    logic [ERR_N-1:0] err_set;
    logic             err_reg [ERR_N];
    logic             eop_map_reg [DEPTH];
    logic [ENTRY_W-1:0] mem_rdata;
    marker_t          wr_mark, rd_mark;

    assign wr_mark = '{sop: wr_sop, eop: wr_eop};

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        in_frame_next   = in_frame_reg;
        drop_next       = drop_reg;
        wr_addr_ptr     = wr_ptr_reg;
        mem_we          = 1'b0;
        commit          = 1'b0;
        drop_pulse      = 1'b0;
        err_set         = '0;

        if (wr_en) begin
            if (STORE_FWD && drop_reg) begin
                // Discarding the tail of an overflowed frame; its EOP ends the discard.
                drop_next = !wr_eop;
            end else if (full_reg) begin
                err_set[ERR_OVERFLOW] = 1'b1;
                if (STORE_FWD && in_frame_reg) begin
                    wr_ptr_next   = commit_ptr_reg;
                    drop_pulse    = 1'b1;
                    in_frame_next = 1'b0;
                    drop_next     = !wr_eop;
                end
            end else if (wr_sop) begin
                if (in_frame_reg) begin
                    err_set[ERR_FRAME] = 1'b1;
                    if (STORE_FWD) begin
                        // Abandon the open frame; the new SOP overwrites its first slot.
                        wr_addr_ptr = commit_ptr_reg;
                        drop_pulse  = 1'b1;
                    end
                end
                mem_we        = 1'b1;
                wr_ptr_next   = wr_addr_ptr + LVL_W'(1);
                in_frame_next = !wr_eop;
                commit        = wr_eop;
            end else if (in_frame_reg) begin
                mem_we        = 1'b1;
                wr_ptr_next   = wr_ptr_reg + LVL_W'(1);
                in_frame_next = !wr_eop;
                commit        = wr_eop;
            end else begin
                // Word with no preceding SOP: not stored.
                err_set[ERR_FRAME] = 1'b1;
            end
        end

        if (commit || !STORE_FWD) begin
            commit_ptr_next = wr_ptr_next;
        end

        rd_acc                 = rd_en && !empty_reg;
        err_set[ERR_UNDERFLOW] = rd_en && empty_reg;
        rd_ptr_next            = rd_ptr_reg + LVL_W'(rd_acc);
        // EOP bits are mirrored in flops so the frame count can drop on the
        // read edge itself, before the RAM data comes out.
        rd_eop_dec             = rd_acc && eop_map_reg[rd_ptr_reg[AW-1:0]];
        frame_cnt_next         = frame_cnt_reg + LVL_W'(commit) - LVL_W'(rd_eop_dec);

        wr_lvl_next = wr_ptr_next - rd_ptr_next;
        rd_lvl_next = commit_ptr_next - rd_ptr_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg       <= '0;
            commit_ptr_reg   <= '0;
            rd_ptr_reg       <= '0;
            frame_cnt_reg    <= '0;
            wr_lvl_reg       <= '0;
            rd_lvl_reg       <= '0;
            in_frame_reg     <= 1'b0;
            drop_reg         <= 1'b0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            rd_valid_reg     <= 1'b0;
            data_seen_reg    <= 1'b0;
            frame_drop_reg   <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            commit_ptr_reg   <= commit_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            frame_cnt_reg    <= frame_cnt_next;
            wr_lvl_reg       <= wr_lvl_next;
            rd_lvl_reg       <= rd_lvl_next;
            in_frame_reg     <= in_frame_next;
            drop_reg         <= drop_next;
            full_reg         <= (wr_lvl_next == DEPTH_LVL);
            empty_reg        <= (rd_lvl_next == '0);
            almost_full_reg  <= (wr_lvl_next >= af_thresh);
            almost_empty_reg <= (rd_lvl_next <= ae_thresh);
            rd_valid_reg     <= rd_acc;
            frame_drop_reg   <= drop_pulse;
            if (rd_acc) begin
                data_seen_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < ERR_N; gi++) begin : g_err
        // A new error in the same cycle as clr_err wins.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_reg[gi] <= 1'b0;
            end else begin
                err_reg[gi] <= err_set[gi] | (err_reg[gi] & ~clr_err);
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_eop_map
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                eop_map_reg[gi] <= 1'b0;
            end else if (mem_we && (wr_addr_ptr[AW-1:0] == AW'(gi))) begin
                eop_map_reg[gi] <= wr_eop;
            end
        end
    end

    frame_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr_ptr[AW-1:0]),
        .wdata ({wr_mark, wr_data}),
        .re    (rd_acc),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (mem_rdata)
    );

    // The RAM read register has no reset; present zeros until the first read.
    assign rd_mark      = data_seen_reg ? marker_t'(mem_rdata[ENTRY_W-1 -: 2]) : '0;
    assign rd_data      = data_seen_reg ? mem_rdata[DATA_W-1:0] : '0;
    assign rd_sop       = rd_mark.sop;
    assign rd_eop       = rd_mark.eop;
    assign rd_valid     = rd_valid_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign wr_lvl       = wr_lvl_reg;
    assign rd_lvl       = rd_lvl_reg;
    assign frame_cnt    = frame_cnt_reg;
    assign overflow     = err_reg[ERR_OVERFLOW];
    assign underflow    = err_reg[ERR_UNDERFLOW];
    assign frame_err    = err_reg[ERR_FRAME];
    assign frame_drop   = frame_drop_reg;

endmodule

// File: tb/tb_sync_frame_fifo.sv
// tb_sync_frame_fifo: directed bench for sync_frame_fifo. Two instances share
// one stimulus stream: s_* is store-and-forward, c_* is cut-through.
module tb_sync_frame_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0, wr_sop = 1'b0, wr_eop = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [31:0] wr_data = '0;
    logic [5:0]  af_thresh = 6'd28, ae_thresh = 6'd2;

    logic [31:0] s_rd_data, c_rd_data;
    logic        s_rd_sop, s_rd_eop, s_rd_valid, c_rd_sop, c_rd_eop, c_rd_valid;
    logic        s_full, s_empty, s_af, s_ae, c_full, c_empty, c_af, c_ae;
    logic [5:0]  s_wr_lvl, s_rd_lvl, s_frame_cnt, c_wr_lvl, c_rd_lvl, c_frame_cnt;
    logic        s_ovf, s_udf, s_ferr, s_drop, c_ovf, c_udf, c_ferr, c_drop;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_frame_fifo #(.DATA_W(32), .DEPTH(32), .STORE_FWD(1'b1)) u_sf (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sop(wr_sop), .wr_eop(wr_eop),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(s_rd_data), .rd_sop(s_rd_sop),
        .rd_eop(s_rd_eop), .rd_valid(s_rd_valid), .af_thresh(af_thresh),
        .ae_thresh(ae_thresh), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .wr_lvl(s_wr_lvl), .rd_lvl(s_rd_lvl),
        .frame_cnt(s_frame_cnt), .overflow(s_ovf), .underflow(s_udf),
        .frame_err(s_ferr), .frame_drop(s_drop), .clr_err(clr_err)
    );

    sync_frame_fifo #(.DATA_W(32), .DEPTH(32), .STORE_FWD(1'b0)) u_ct (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sop(wr_sop), .wr_eop(wr_eop),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(c_rd_data), .rd_sop(c_rd_sop),
        .rd_eop(c_rd_eop), .rd_valid(c_rd_valid), .af_thresh(af_thresh),
        .ae_thresh(ae_thresh), .full(c_full), .empty(c_empty), .almost_full(c_af),
        .almost_empty(c_ae), .wr_lvl(c_wr_lvl), .rd_lvl(c_rd_lvl),
        .frame_cnt(c_frame_cnt), .overflow(c_ovf), .underflow(c_udf),
        .frame_err(c_ferr), .frame_drop(c_drop), .clr_err(clr_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction: inputs held for a single clock edge, then released.
    task automatic drive(input logic we, input logic sop, input logic eop,
                         input logic [31:0] d, input logic re, input logic clr);
        wr_en = we; wr_sop = sop; wr_eop = eop; wr_data = d; rd_en = re; clr_err = clr;
        $display("txn t=%0t we=%0b sop=%0b eop=%0b d=%08h re=%0b clr=%0b",
                 $time, we, sop, eop, d, re, clr);
        step();
        wr_en = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state
        check_eq("rst_empty", s_empty, 1);
        check_eq("rst_almost_empty", s_ae, 1);
        check_eq("rst_full", s_full, 0);
        check_eq("rst_almost_full", s_af, 0);
        check_eq("rst_wr_lvl", s_wr_lvl, 0);
        check_eq("rst_rd_valid", s_rd_valid, 0);
        check_eq("rst_rd_data", s_rd_data, 0);
        check_eq("rst_overflow", s_ovf, 0);

        // 4-word frame, store-and-forward
        drive(1, 1, 0, 32'hA0, 0, 0);
        check_eq("sf_rd_lvl_w0", s_rd_lvl, 0);
        drive(1, 0, 0, 32'hA1, 0, 0);
        drive(1, 0, 0, 32'hA2, 0, 0);
        check_eq("sf_wr_lvl_w2", s_wr_lvl, 3);
        check_eq("sf_rd_lvl_w2", s_rd_lvl, 0);
        drive(1, 0, 1, 32'hA3, 0, 0);
        check_eq("sf_wr_lvl_eop", s_wr_lvl, 4);
        check_eq("sf_rd_lvl_eop", s_rd_lvl, 4);
        check_eq("sf_frame_cnt_eop", s_frame_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            check_eq("sf_rd_valid", s_rd_valid, 1);
            check_eq("sf_rd_data", s_rd_data, 32'hA0 + i);
            check_eq("sf_rd_sop", s_rd_sop, (i == 0) ? 1 : 0);
            check_eq("sf_rd_eop", s_rd_eop, (i == 3) ? 1 : 0);
            check_eq("sf_rd_lvl_rd", s_rd_lvl, 3 - i);
        end
        check_eq("sf_frame_cnt_rd", s_frame_cnt, 0);
        drive(0, 0, 0, 0, 0, 0);
        check_eq("sf_rd_valid_idle", s_rd_valid, 0);
        check_eq("sf_rd_data_hold", s_rd_data, 32'hA3);

        // 40-word frame overflows and is dropped
        for (int i = 0; i < 40; i++) begin
            drive(1, i == 0, i == 39, 32'hB00 + i, 0, 0);
            if (i == 31) begin
                check_eq("ovf_full", s_full, 1);
                check_eq("ovf_wr_lvl_32", s_wr_lvl, 32);
                check_eq("ovf_rd_lvl_32", s_rd_lvl, 0);
            end
            if (i == 32) begin
                check_eq("ovf_flag", s_ovf, 1);
                check_eq("ovf_drop_pulse", s_drop, 1);
                check_eq("ovf_wr_lvl_rewind", s_wr_lvl, 0);
            end
            if (i == 33) check_eq("ovf_drop_end", s_drop, 0);
        end
        check_eq("ovf_wr_lvl_after", s_wr_lvl, 0);
        check_eq("ovf_frame_cnt", s_frame_cnt, 0);
        drive(1, 1, 0, 32'hC0, 0, 0);
        drive(1, 0, 0, 32'hC1, 0, 0);
        drive(1, 0, 1, 32'hC2, 0, 0);
        check_eq("post_ovf_rd_lvl", s_rd_lvl, 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            check_eq("post_ovf_data", s_rd_data, 32'hC0 + i);
        end

        // Underflow and clear priority
        do_reset();
        drive(0, 0, 0, 0, 1, 0);
        check_eq("udf_flag", s_udf, 1);
        check_eq("udf_rd_valid", s_rd_valid, 0);
        check_eq("udf_rd_lvl", s_rd_lvl, 0);
        drive(0, 0, 0, 0, 1, 1);
        check_eq("udf_clr_priority", s_udf, 1);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("udf_cleared", s_udf, 0);

        // Cut-through fill: thresholds, full, rejected write with read
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1, i == 0, 0, 32'hD00 + i, 0, 0);
            if (i == 1)  check_eq("ct_ae_lvl2", c_ae, 1);
            if (i == 2)  check_eq("ct_ae_lvl3", c_ae, 0);
            if (i == 26) check_eq("ct_af_lvl27", c_af, 0);
            if (i == 27) check_eq("ct_af_lvl28", c_af, 1);
            if (i == 30) check_eq("ct_full_lvl31", c_full, 0);
        end
        check_eq("ct_full_lvl32", c_full, 1);
        check_eq("ct_rd_lvl32", c_rd_lvl, 32);
        drive(1, 0, 0, 32'hDFF, 1, 0);
        check_eq("ct_ovf", c_ovf, 1);
        check_eq("ct_wr_lvl31", c_wr_lvl, 31);
        check_eq("ct_rd_data", c_rd_data, 32'hD00);
        check_eq("ct_rd_sop", c_rd_sop, 1);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("ct_ovf_clr", c_ovf, 0);

        // SOP inside an open frame
        do_reset();
        drive(1, 1, 0, 32'hE0, 0, 0);
        drive(1, 0, 0, 32'hE1, 0, 0);
        drive(1, 0, 0, 32'hE2, 0, 0);
        drive(1, 1, 0, 32'hE3, 0, 0);
        check_eq("ferr_sf_flag", s_ferr, 1);
        check_eq("ferr_sf_drop", s_drop, 1);
        check_eq("ferr_ct_flag", c_ferr, 1);
        check_eq("ferr_ct_drop", c_drop, 0);
        drive(1, 0, 1, 32'hE4, 0, 0);
        check_eq("ferr_sf_rd_lvl", s_rd_lvl, 2);
        check_eq("ferr_sf_frame_cnt", s_frame_cnt, 1);
        check_eq("ferr_ct_wr_lvl", c_wr_lvl, 5);
        check_eq("ferr_ct_frame_cnt", c_frame_cnt, 1);
        drive(0, 0, 0, 0, 1, 0);
        check_eq("ferr_rd0_data", s_rd_data, 32'hE3);
        check_eq("ferr_rd0_sop", s_rd_sop, 1);
        drive(0, 0, 0, 0, 1, 0);
        check_eq("ferr_rd1_data", s_rd_data, 32'hE4);
        check_eq("ferr_rd1_eop", s_rd_eop, 1);

        // Reset in the middle of a frame
        drive(1, 1, 0, 32'hF0, 0, 0);
        drive(1, 0, 0, 32'hF1, 0, 0);
        check_eq("mid_wr_lvl_pre", s_wr_lvl, 2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_wr_lvl", s_wr_lvl, 0);
        check_eq("mid_rst_empty", s_empty, 1);
        check_eq("mid_rst_rd_data", s_rd_data, 0);
        check_eq("mid_rst_rd_eop", s_rd_eop, 0);
        check_eq("mid_rst_frame_err", s_ferr, 0);
        check_eq("mid_rst_drop", s_drop, 0);
        check_eq("mid_rst_ct_wr_lvl", c_wr_lvl, 0);
        rst_n = 1'b1;
        drive(1, 1, 1, 32'h99, 0, 0);
        check_eq("post_rst_rd_lvl", s_rd_lvl, 1);
        check_eq("post_rst_frame_cnt", s_frame_cnt, 1);
        check_eq("post_rst_ferr", s_ferr, 0);
        drive(0, 0, 0, 0, 1, 0);
        check_eq("post_rst_data", s_rd_data, 32'h99);
        check_eq("post_rst_sop_eop", {s_rd_sop, s_rd_eop}, 2'b11);
        check_eq("post_rst_frame_cnt_rd", s_frame_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
